// File: rtl/regfile_pkg.sv
// regfile_pkg: shared sizes and types for the 32-entry register file.
//   REG_ADDR_W   - register index width (5)
//   NUM_REGS     - number of architectural registers (32)
//   ZERO_REG_IDX - index of the optional hardwired zero register (31)
//   reg_addr_t   - register index type
//   reg_onehot_t - one-hot word-line enable type
package regfile_pkg;

  localparam int unsigned REG_ADDR_W   = 5;
  localparam int unsigned NUM_REGS     = 32;
  localparam int unsigned ZERO_REG_IDX = 31;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [NUM_REGS-1:0]   reg_onehot_t;

endpackage

// File: rtl/regfile_write_decoder_decoders.sv
// Combinational one-hot decoders used to build the register-file write decoder.
//
// decoder2_4: 2-to-4 decoder with enable (bank predecoder)
//   i_en  - enable; 0 forces o_dec to all zero
//   i_sel - 2-bit select
//   o_dec - 4-bit one-hot output
//
// decoder3_8: 3-to-8 decoder with enable (per-bank word-line decode)
//   i_en  - enable; 0 forces o_dec to all zero
//   i_sel - 3-bit select
//   o_dec - 8-bit one-hot output
module decoder2_4 (
  input  logic       i_en,
  input  logic [1:0] i_sel,
  output logic [3:0] o_dec
);

  always_comb begin
    o_dec = '0;
    if (i_en) o_dec[i_sel] = 1'b1;
  end

endmodule

module decoder3_8 (
  input  logic       i_en,
  input  logic [2:0] i_sel,
  output logic [7:0] o_dec
);

  always_comb begin
    o_dec = '0;
    if (i_en) o_dec[i_sel] = 1'b1;
  end

endmodule

// File: rtl/regfile_write_decoder.sv
// regfile_write_decoder: registered 5-to-32 one-hot write-enable decoder.
//
// A 2-to-4 predecoder on addr[4:3] (gated by reg_write) enables one of four
// 3-to-8 decoders on addr[2:0]; the 32-bit result is registered so the
// register-file write enables are glitch-free and clock-aligned.
//
// Ports:
//   clk       - rising-edge clock
//   rst_n     - asynchronous active-low reset, clears wr_en
//   reg_write - write strobe; 0 forces all enables low
//   addr      - destination register index
//   wr_en     - registered one-hot write enable, bit i selects register i
//
// Build option:
//   REGFILE_ZERO_REG_EN - when defined, register 31 is a hardwired zero
//                         register and never receives a write enable.
module regfile_write_decoder
  import regfile_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        reg_write,
  input  logic [4:0]  addr,
  output logic [31:0] wr_en
);

  logic [3:0]  w_sel;
  reg_onehot_t w_dec;
  reg_onehot_t w_next;
  reg_onehot_t r_wr_en;

  decoder2_4 u_predec (
    .i_en  (reg_write),
    .i_sel (addr[4:3]),
    .o_dec (w_sel)
  );

  for (genvar g = 0; g < 4; g++) begin : g_bank
    decoder3_8 u_bank (
      .i_en  (w_sel[g]),
      .i_sel (addr[2:0]),
      .o_dec (w_dec[8*g +: 8])
    );
  end

`ifdef REGFILE_ZERO_REG_EN
  always_comb begin
    w_next               = w_dec;
    w_next[ZERO_REG_IDX] = 1'b0;
  end
`else
  assign w_next = w_dec;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_wr_en <= '0;
    else        r_wr_en <= w_next;
  end

  assign wr_en = r_wr_en;

endmodule

// File: tb/tb_regfile_write_decoder.sv
module tb_regfile_write_decoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        reg_write = 1'b0;
  logic [4:0]  addr = '0;
  logic [31:0] wr_en;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic        sim_done = 1'b0;

  regfile_write_decoder u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .reg_write (reg_write),
    .addr      (addr),
    .wr_en     (wr_en)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Drive on the falling edge, check 1 time unit after the next rising edge.
  task automatic step(input logic rw, input logic [4:0] a, input logic [31:0] exp, input string tag);
    @(negedge clk);
    reg_write = rw;
    addr      = a;
    @(posedge clk);
    #1;
    check(tag, wr_en, exp);
  endtask

  function automatic logic [31:0] onehot(input logic [4:0] a);
    logic [31:0] v;
    v = 32'h0;
    v[a] = 1'b1;
`ifdef REGFILE_ZERO_REG_EN
    if (a == 5'd31) v = 32'h0;
`endif
    return v;
  endfunction

  // At most one write enable may be high at any time.
  always @(negedge clk) begin
    if (!sim_done) check("onehot_inv", {31'd0, ($countones(wr_en) <= 1)}, 32'd1);
  end

  initial begin
    // Reset with an active write pending: output must clear without a clock.
    #1;
    reg_write = 1'b1;
    addr      = 5'd5;
    rst_n     = 1'b0;
    #2;
    check("reset_async", wr_en, 32'h0);
    @(posedge clk);
    #1;
    check("reset_hold", wr_en, 32'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("reset_release", wr_en, 32'h0000_0020);

    // Write sweep
    for (int i = 0; i < 32; i++) step(1'b1, 5'(i), onehot(5'(i)), "write_sweep");

    // Disabled sweep (first step also proves no hold-over from addr 31)
    for (int i = 0; i < 32; i++) step(1'b0, 5'(i), 32'h0, "disabled_sweep");

    // Bank boundaries
    step(1'b1, 5'd7,  32'h0000_0080, "bound_7");
    step(1'b1, 5'd8,  32'h0000_0100, "bound_8");
    step(1'b1, 5'd15, 32'h0000_8000, "bound_15");
    step(1'b1, 5'd16, 32'h0001_0000, "bound_16");
    step(1'b1, 5'd23, 32'h0080_0000, "bound_23");
    step(1'b1, 5'd24, 32'h0100_0000, "bound_24");
    step(1'b0, 5'd24, 32'h0,         "strobe_off");

    // Explicit addr 31 vector
`ifdef REGFILE_ZERO_REG_EN
    step(1'b1, 5'd31, 32'h0,         "addr31");
`else
    step(1'b1, 5'd31, 32'h8000_0000, "addr31");
`endif

    // Async reset mid-stream
    step(1'b1, 5'd12, 32'h0000_1000, "pre_reset");
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midreset_async", wr_en, 32'h0);
    @(posedge clk);
    #1;
    check("midreset_hold", wr_en, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("midreset_release", wr_en, 32'h0000_1000);

    // Fast-changing address
    step(1'b1, 5'd3,  32'h0000_0008, "track_3");
    step(1'b1, 5'd28, 32'h1000_0000, "track_28");
    step(1'b1, 5'd0,  32'h0000_0001, "track_0");
    step(1'b0, 5'd9,  32'h0,         "track_off");

    sim_done = 1'b1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/regfile_write_decoder.md
Name: regfile_write_decoder

Overview:
- Registered 5-to-32 write-enable decoder for the 32-entry register file.
- Converts a 5-bit write address plus a write strobe into a 32-bit one-hot word-line enable.
- Built from a 2-to-4 predecoder (decoder2_4) driving the enables of four 3-to-8 decoders (decoder3_8).
- Output is registered so register-file write enables are glitch-free and aligned to the clock.

Parameters:
- None; address width 5 and output width 32 are fixed.

Ports:
- clk        input   1   rising-edge clock
- rst_n      input   1   asynchronous active-low reset
- reg_write  input   1   write strobe; 0 forces all enables low
- addr       input   5   destination register index
- wr_en      output  32  registered one-hot write enable, bit i selects register i

Behaviour:
- Predecode: sel[3:0] = 2-to-4 decode of addr[4:3], all zero when reg_write=0.
- Bank decode:
  - Bank g (g=0..3) = 3-to-8 decode of addr[2:0], gated by sel[g].
  - Bank g drives next-state bits [8g+7:8g].
- Combinational next-state: bit addr = reg_write; all other bits = 0.
- Register:
  - wr_en loads the next-state value on every rising clk edge.
  - Latency is exactly 1 cycle from addr/reg_write to wr_en.
- Reset:
  - rst_n=0 clears wr_en to 32'h0 immediately, with no clock required.
  - While rst_n is low, wr_en holds 0 regardless of inputs.
  - After rst_n is deasserted, the first rising edge loads the decoded value.
- Reset asserted mid-operation: wr_en drops to 0 asynchronously and the pending write is discarded.
- Invariant: wr_en is always zero or exactly one-hot; two or more bits high at once is a design error.
- reg_write=0 with any addr: wr_en=0 after the next edge.
- Group boundaries 7/8, 15/16, 23/24: exactly one bank is enabled; no bit from an adjacent bank asserts.
- addr changing every cycle: wr_en tracks each value, delayed by one cycle, with no hold-over bits.
- No internal state beyond the 32-bit output register.

Optional Feature:
- Macro: REGFILE_ZERO_REG_EN.
- Defined: register 31 is the hardwired zero register.
  - addr=31 with reg_write=1 yields wr_en=0.
  - All other addresses behave as normal.
- Undefined: addr=31 with reg_write=1 yields wr_en=32'h8000_0000.

Decomposition:
- Shared package regfile_pkg:
  - REG_ADDR_W=5.
  - NUM_REGS=32.
  - typedef reg_addr_t (logic [4:0]).
  - typedef reg_onehot_t (logic [31:0]).
  - ZERO_REG_IDX=31.
- Sub-modules:
  - decoder3_8 (3-bit in, enable, 8-bit one-hot out, all zero when disabled) is instantiated four times.
  - decoder2_4 (same contract, 2-bit in) is the predecoder.
  - Both are purely combinational.
- Top level holds only the gating, the optional zero-register mask and the output register.

Test Plan:
- Reset: rst_n=0 with reg_write=1, addr=5 -> wr_en=0 with no clock edge; release and clock once -> wr_en=32'h0000_0020.
- Write sweep: reg_write=1, addr=0..31, one per cycle -> one cycle later wr_en = 1<<addr; bit 31 gives 32'h8000_0000 (zero when REGFILE_ZERO_REG_EN is defined).
- Disabled sweep: reg_write=0, addr=0..31 -> wr_en=0 on every cycle.
- Bank boundaries: addr 7,8,15,16,23,24 back-to-back -> 32'h80, 32'h100, 32'h8000, 32'h1_0000, 32'h80_0000, 32'h100_0000.
- Async reset mid-stream: rst_n pulsed low between edges while addr=12, reg_write=1 -> wr_en=0 immediately; returns to 32'h1000 on the first edge after release.
- Invariant check: every cycle, $countones(wr_en) <= 1.
